// File: rtl/axi_lite_led_pkg.sv
// Shared constants, control-register layout and byte-merge helper for the
// AXI4-Lite LED controller.
package axi_lite_led_pkg;

  // Register word offsets (byte address bits [3:2])
  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_PATTERN = 2'd1;
  localparam logic [1:0] REG_PERIOD  = 2'd2;
  localparam logic [1:0] REG_DUTY    = 2'd3;

  // CTRL.MODE encodings; the fourth encoding behaves as static
  localparam logic [1:0] MODE_STATIC = 2'd0;
  localparam logic [1:0] MODE_BLINK  = 2'd1;
  localparam logic [1:0] MODE_PWM    = 2'd2;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Field view of the CTRL register; upper bits are stored but have no effect
  typedef struct packed {
    logic [28:0] rsvd;
    logic [1:0]  mode;
    logic        en;
  } ctrl_t;

  // Merge write data into the current register value under the byte enables
  function automatic logic [31:0] apply_wstrb(input logic [31:0] cur,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = cur;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = wdata[8*b +: 8];
      end else begin
        res[8*b +: 8] = cur[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/led_pattern_gen.sv
// Blink / PWM counters and the registered LED output mux.
module led_pattern_gen
  import axi_lite_led_pkg::*;
#(
  parameter int NUM_LEDS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         ctrl,
  input  logic [31:0]         pattern,
  input  logic [31:0]         period,
  input  logic [31:0]         duty,
  input  logic                restart,
  output logic [NUM_LEDS-1:0] led
);

  ctrl_t               ctrl_s;
  logic [NUM_LEDS-1:0] pattern_s;
  logic                blink_active_s;
  logic                pwm_active_s;
  logic                blink_wrap_s;
  logic [NUM_LEDS-1:0] led_next_s;
  logic [31:0]         blink_cnt_r;
  logic                phase_r;
  logic [7:0]          pwm_cnt_r;
  logic [NUM_LEDS-1:0] led_r;
  logic                unused_s;

  assign ctrl_s    = ctrl;
  assign pattern_s = pattern[NUM_LEDS-1:0];
  assign unused_s  = ^{ctrl_s.rsvd, duty[31:8], pattern};

  // PERIOD of 0 or 1 toggles every clock; the >= guards against a counter
  // left above a freshly shrunk period
  assign blink_wrap_s = (period <= 32'd1) || (blink_cnt_r >= (period - 32'd1));

  // Decode which counter is allowed to run
  always_comb begin
    blink_active_s = 1'b0;
    pwm_active_s   = 1'b0;
    if (ctrl_s.en) begin
      case (ctrl_s.mode)
        MODE_BLINK: blink_active_s = 1'b1;
        MODE_PWM:   pwm_active_s   = 1'b1;
        default: begin
          blink_active_s = 1'b0;
          pwm_active_s   = 1'b0;
        end
      endcase
    end else begin
      blink_active_s = 1'b0;
      pwm_active_s   = 1'b0;
    end
  end

  // Blink half-period counter and phase; restart or inactivity parks at phase 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_r <= 32'd0;
      phase_r     <= 1'b0;
    end else if (restart || !blink_active_s) begin
      blink_cnt_r <= 32'd0;
      phase_r     <= 1'b1;
    end else if (blink_wrap_s) begin
      blink_cnt_r <= 32'd0;
      phase_r     <= ~phase_r;
    end else begin
      blink_cnt_r <= blink_cnt_r + 32'd1;
      phase_r     <= phase_r;
    end
  end

  // Free-running 8-bit PWM counter, held at zero outside PWM mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_r <= 8'd0;
    end else if (!pwm_active_s) begin
      pwm_cnt_r <= 8'd0;
    end else begin
      pwm_cnt_r <= pwm_cnt_r + 8'd1;
    end
  end

  // Select the LED value for the current mode
  always_comb begin
    led_next_s = {NUM_LEDS{1'b0}};
    if (!ctrl_s.en) begin
      led_next_s = {NUM_LEDS{1'b0}};
    end else begin
      case (ctrl_s.mode)
        MODE_BLINK: led_next_s = pattern_s & {NUM_LEDS{phase_r}};
        MODE_PWM:   led_next_s = (pwm_cnt_r < duty[7:0]) ? pattern_s : {NUM_LEDS{1'b0}};
        default:    led_next_s = pattern_s;
      endcase
    end
  end

  // Register the LED drive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_r <= {NUM_LEDS{1'b0}};
    end else begin
      led_r <= led_next_s;
    end
  end

  assign led = led_r;

endmodule

// File: rtl/axi_lite_led_ctrl.sv
// AXI4-Lite slave with four 32-bit control registers driving board LEDs.
module axi_lite_led_ctrl
  import axi_lite_led_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int NUM_LEDS           = 8
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic [NUM_LEDS-1:0]             led
);

  logic        aw_ready_r;
  logic        bvalid_r;
  logic        ar_ready_r;
  logic        rvalid_r;
  logic [31:0] rdata_r;
  logic [31:0] regs_r [0:3];
  logic        wr_accept_s;
  logic        rd_accept_s;
  logic [1:0]  wr_idx_s;
  logic [1:0]  rd_idx_s;
  logic        restart_s;
  logic        unused_s;

  assign wr_idx_s = s00_axi_awaddr[3:2];
  assign rd_idx_s = s00_axi_araddr[3:2];
  assign unused_s = ^{s00_axi_awprot, s00_axi_arprot,
                      s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  // A write is taken only with both address and data present and no response pending
  assign wr_accept_s = s00_axi_awvalid && s00_axi_wvalid && !aw_ready_r && !bvalid_r;
  assign rd_accept_s = s00_axi_arvalid && !ar_ready_r && !rvalid_r;

  // Writes to CTRL or PERIOD realign the blink phase
  assign restart_s = wr_accept_s && ((wr_idx_s == REG_CTRL) || (wr_idx_s == REG_PERIOD));

  // Write-channel handshake: one-cycle ready pulse, then hold bvalid until bready
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      aw_ready_r <= 1'b0;
      bvalid_r   <= 1'b0;
    end else begin
      aw_ready_r <= wr_accept_s;
      if (aw_ready_r) begin
        bvalid_r <= 1'b1;
      end else if (s00_axi_bready) begin
        bvalid_r <= 1'b0;
      end else begin
        bvalid_r <= bvalid_r;
      end
    end
  end

  // Register file, byte-merged on the accepting edge
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      for (int i = 0; i < 4; i++) begin
        regs_r[i] <= 32'd0;
      end
    end else if (wr_accept_s) begin
      regs_r[wr_idx_s] <= apply_wstrb(regs_r[wr_idx_s], s00_axi_wdata, s00_axi_wstrb);
    end else begin
      regs_r[wr_idx_s] <= regs_r[wr_idx_s];
    end
  end

  // Read channel: capture data with arready, present it until rready
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      ar_ready_r <= 1'b0;
      rvalid_r   <= 1'b0;
      rdata_r    <= 32'd0;
    end else begin
      ar_ready_r <= rd_accept_s;
      if (rd_accept_s) begin
        rdata_r <= regs_r[rd_idx_s];
      end else begin
        rdata_r <= rdata_r;
      end
      if (ar_ready_r) begin
        rvalid_r <= 1'b1;
      end else if (s00_axi_rready) begin
        rvalid_r <= 1'b0;
      end else begin
        rvalid_r <= rvalid_r;
      end
    end
  end

  assign s00_axi_awready = aw_ready_r;
  assign s00_axi_wready  = aw_ready_r;
  assign s00_axi_bvalid  = bvalid_r;
  assign s00_axi_bresp   = RESP_OKAY;
  assign s00_axi_arready = ar_ready_r;
  assign s00_axi_rvalid  = rvalid_r;
  assign s00_axi_rdata   = rdata_r;
  assign s00_axi_rresp   = RESP_OKAY;

  led_pattern_gen #(
    .NUM_LEDS (NUM_LEDS)
  ) u_pattern_gen (
    .clk     (s00_axi_aclk),
    .rst_n   (s00_axi_aresetn),
    .ctrl    (regs_r[REG_CTRL]),
    .pattern (regs_r[REG_PATTERN]),
    .period  (regs_r[REG_PERIOD]),
    .duty    (regs_r[REG_DUTY]),
    .restart (restart_s),
    .led     (led)
  );

endmodule

// File: tb/tb_axi_lite_led_ctrl.sv
// Self-checking bench for axi_lite_led_ctrl with a register/LED reference model.
module tb_axi_lite_led_ctrl;

  localparam int NL = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [3:0]    awaddr = 4'd0;
  logic [2:0]    awprot = 3'd0;
  logic          awvalid = 1'b0;
  logic          awready;
  logic [31:0]   wdata = 32'd0;
  logic [3:0]    wstrb = 4'd0;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready = 1'b0;
  logic [3:0]    araddr = 4'd0;
  logic [2:0]    arprot = 3'd0;
  logic          arvalid = 1'b0;
  logic          arready;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready = 1'b0;
  logic [NL-1:0] led;

  int          n_total = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  logic [31:0] model_regs [0:3];

  axi_lite_led_ctrl #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (4),
    .NUM_LEDS           (NL)
  ) dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rst_n),
    .s00_axi_awaddr  (awaddr),
    .s00_axi_awprot  (awprot),
    .s00_axi_awvalid (awvalid),
    .s00_axi_awready (awready),
    .s00_axi_wdata   (wdata),
    .s00_axi_wstrb   (wstrb),
    .s00_axi_wvalid  (wvalid),
    .s00_axi_wready  (wready),
    .s00_axi_bresp   (bresp),
    .s00_axi_bvalid  (bvalid),
    .s00_axi_bready  (bready),
    .s00_axi_araddr  (araddr),
    .s00_axi_arprot  (arprot),
    .s00_axi_arvalid (arvalid),
    .s00_axi_arready (arready),
    .s00_axi_rdata   (rdata),
    .s00_axi_rresp   (rresp),
    .s00_axi_rvalid  (rvalid),
    .s00_axi_rready  (rready),
    .led             (led)
  );

  // Clock generation
  always #5 clk = ~clk;

  // Edge counter used to time LED behaviour from the accepting edge
  always @(posedge clk) cyc <= cyc + 1;

  // Safety net against a hung handshake
  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge_bytes(input logic [31:0] cur, input logic [31:0] d,
                                              input logic [3:0] s);
    logic [31:0] r;
    r = cur;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Blink: phase starts on and flips after every max(PERIOD,1) running clocks;
  // the LED shows the state one clock late.
  function automatic logic [7:0] blink_exp(input int k, input int per, input logic [7:0] pat);
    int pe;
    pe = (per < 1) ? 1 : per;
    return ((((k - 1) / pe) % 2) == 0) ? pat : 8'h00;
  endfunction

  // PWM: counter value (k-1) mod 256 compared against duty.
  function automatic logic [7:0] pwm_exp(input int k, input int duty, input logic [7:0] pat);
    return (((k - 1) % 256) < duty) ? pat : 8'h00;
  endfunction

  task automatic wait_sig(input string tag, input int which);
    int t;
    t = 0;
    while (t < 40) begin
      if ((which == 0 && awready === 1'b1) || (which == 1 && bvalid === 1'b1) ||
          (which == 2 && arready === 1'b1) || (which == 3 && rvalid === 1'b1)) break;
      @(negedge clk);
      t++;
    end
    if (t >= 40) check_val(tag, 32'(t), 32'd0);
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    @(negedge clk);
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    wait_sig("aw_timeout", 0);
    acc_cyc = cyc;
    check_val("wready_with_awready", 32'(wready), 32'd1);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    wait_sig("b_timeout", 1);
    check_val("bresp", 32'(bresp), 32'd0);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    model_regs[addr[3:2]] = merge_bytes(model_regs[addr[3:2]], data, strb);
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
    @(negedge clk);
    araddr = addr; arvalid = 1'b1;
    wait_sig("ar_timeout", 2);
    @(negedge clk);
    arvalid = 1'b0;
    wait_sig("r_timeout", 3);
    data = rdata;
    check_val("rresp", 32'(rresp), 32'd0);
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic read_check(input logic [3:0] addr, input string tag);
    logic [31:0] d;
    axi_read(addr, d);
    check_val(tag, d, model_regs[addr[3:2]]);
  endtask

  initial begin
    logic [31:0] d, old;
    int per, duty, ons, cnt;
    logic [7:0] pat;
    for (int i = 0; i < 4; i++) model_regs[i] = 32'd0;

    // Reset
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_awready", 32'(awready), 32'd0);
    check_val("rst_bvalid", 32'(bvalid), 32'd0);
    check_val("rst_arready", 32'(arready), 32'd0);
    check_val("rst_rvalid", 32'(rvalid), 32'd0);
    check_val("rst_rdata", rdata, 32'd0);
    check_val("rst_led", 32'(led), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    read_check(4'h0, "rst_reg0");

    // Write/readback of the reference values
    axi_write(4'h0, 32'h0101FFFF, 4'hF);
    axi_write(4'h4, 32'hABCD0001, 4'hF);
    axi_write(4'h8, 32'hDEAD0011, 4'hF);
    axi_write(4'hC, 32'hBEEF0011, 4'hF);
    read_check(4'h0, "rb_reg0");
    read_check(4'h4, "rb_reg1");
    read_check(4'h8, "rb_reg2");
    read_check(4'hC, "rb_reg3");

    // Byte strobes
    axi_write(4'h4, 32'h11223344, 4'hF);
    axi_write(4'h4, 32'hAABBCCDD, 4'b0101);
    axi_read(4'h4, d);
    check_val("strobe_const", d, 32'h11BB33DD);

    // Random writes with random strobes
    for (int i = 0; i < 24; i++) begin
      logic [3:0] a;
      a = 4'($urandom_range(0, 3) * 4);
      axi_write(a, $urandom, 4'($urandom_range(0, 15)));
      a = 4'($urandom_range(0, 3) * 4);
      read_check(a, "rand_rb");
    end

    // Static mode
    axi_write(4'h0, 32'h0, 4'hF);
    axi_write(4'h4, 32'h000000A5, 4'hF);
    axi_write(4'h0, 32'h1, 4'hF);
    @(negedge clk);
    check_val("static_a5", 32'(led), 32'h000000A5);
    axi_write(4'h0, 32'h0, 4'hF);
    @(negedge clk);
    check_val("static_off", 32'(led), 32'd0);
    for (int i = 0; i < 6; i++) begin
      axi_write(4'h4, $urandom, 4'hF);
      axi_write(4'h0, {$urandom_range(0, 7) == 0 ? 29'h1 : 29'h0, (($urandom_range(0, 1) == 1) ? 2'd3 : 2'd0), 1'b1}, 4'hF);
      @(negedge clk);
      check_val("static_rand", 32'(led), 32'(model_regs[1][7:0]));
    end

    // Blink: reference case then random periods
    axi_write(4'h0, 32'h0, 4'hF);
    axi_write(4'h4, 32'h000000FF, 4'hF);
    for (int r = 0; r < 4; r++) begin
      per = (r == 0) ? 4 : int'($urandom_range(0, 6));
      pat = (r == 0) ? 8'hFF : 8'($urandom);
      axi_write(4'h4, {24'd0, pat}, 4'hF);
      axi_write(4'h8, 32'(per), 4'hF);
      axi_write(4'h0, 32'h3, 4'hF);
      for (int i = 0; i < 24; i++) begin
        @(negedge clk);
        check_val("blink", 32'(led), 32'(blink_exp(cyc - acc_cyc, per, pat)));
      end
    end

    // PWM: reference duty plus boundaries and a random one
    for (int r = 0; r < 4; r++) begin
      duty = (r == 0) ? 64 : (r == 1) ? 0 : (r == 2) ? 255 : int'($urandom_range(1, 254));
      axi_write(4'h0, 32'h0, 4'hF);
      axi_write(4'h4, 32'h000000FF, 4'hF);
      axi_write(4'hC, 32'(duty), 4'hF);
      axi_write(4'h0, 32'h5, 4'hF);
      ons = 0;
      cnt = 0;
      for (int i = 0; i < 270; i++) begin
        @(negedge clk);
        check_val("pwm", 32'(led), 32'(pwm_exp(cyc - acc_cyc, duty, 8'hFF)));
        if (cnt < 256) begin
          if (led == 8'hFF) ons++;
          cnt++;
        end
      end
      check_val("pwm_on_count", 32'(ons), 32'(duty));
    end
    axi_write(4'h0, 32'h0, 4'hF);

    // AW three cycles ahead of W
    @(negedge clk);
    awaddr = 4'h4; wdata = 32'h5A5A0F0F; wstrb = 4'hF; awvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("aw_early_noready", 32'({awready, wready}), 32'd0);
    end
    wvalid = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (awready === 1'b1) begin
        cnt++;
        check_val("aw_early_wready", 32'(wready), 32'd1);
      end else if (cnt > 0) begin
        awvalid = 1'b0; wvalid = 1'b0;
      end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    check_val("aw_early_pulses", 32'(cnt), 32'd1);
    check_val("aw_early_bvalid", 32'(bvalid), 32'd1);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    model_regs[1] = 32'h5A5A0F0F;
    read_check(4'h4, "aw_early_rb");

    // bready held low stalls a second write
    @(negedge clk);
    awaddr = 4'hC; wdata = 32'h00000077; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    wait_sig("stall_aw1", 0);
    @(negedge clk);
    awaddr = 4'h8; wdata = 32'h00000123;
    for (int i = 0; i < 5; i++) begin
      check_val("stall_bvalid", 32'(bvalid), 32'd1);
      check_val("stall_noaccept", 32'(awready), 32'd0);
      @(negedge clk);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    model_regs[3] = 32'h00000077;
    wait_sig("stall_aw2", 0);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    wait_sig("stall_b2", 1);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    model_regs[2] = 32'h00000123;
    read_check(4'hC, "stall_rb1");
    read_check(4'h8, "stall_rb2");

    // rready low keeps rdata stable
    @(negedge clk);
    araddr = 4'hC; arvalid = 1'b1;
    wait_sig("rhold_ar", 2);
    @(negedge clk);
    arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_val("rhold_rvalid", 32'(rvalid), 32'd1);
      check_val("rhold_rdata", rdata, model_regs[3]);
      @(negedge clk);
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;

    // Simultaneous read and write of one register returns the old value
    old = model_regs[3];
    @(negedge clk);
    awaddr = 4'hC; wdata = 32'hC0FFEE42; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 4'hC; arvalid = 1'b1;
    wait_sig("rw_aw", 0);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    wait_sig("rw_r", 3);
    check_val("rw_old_value", rdata, old);
    bready = 1'b1; rready = 1'b1;
    @(negedge clk);
    bready = 1'b0; rready = 1'b0;
    model_regs[3] = 32'hC0FFEE42;
    read_check(4'hC, "rw_new_value");

    // Reset while a write response is pending
    axi_write(4'h4, 32'h000000A5, 4'hF);
    axi_write(4'h0, 32'h1, 4'hF);
    @(negedge clk);
    check_val("pre_rst_led", 32'(led), 32'h000000A5);
    awaddr = 4'h4; wdata = 32'h0000003C; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    wait_sig("mid_aw", 0);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check_val("mid_bvalid_before", 32'(bvalid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_val("mid_rst_bvalid", 32'(bvalid), 32'd0);
    check_val("mid_rst_led", 32'(led), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) model_regs[i] = 32'd0;
    repeat (2) @(negedge clk);
    check_val("post_rst_bvalid", 32'(bvalid), 32'd0);
    read_check(4'h0, "post_rst_reg0");
    read_check(4'h4, "post_rst_reg1");
    read_check(4'h8, "post_rst_reg2");
    read_check(4'hC, "post_rst_reg3");
    check_val("post_rst_led", 32'(led), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_lite_led_ctrl.md
Name: axi_lite_led_ctrl

Overview:
- AXI4-Lite slave that sits directly downstream of the AXI4-Lite master BFM in the LED IP block design.
- Holds four 32-bit control registers at offsets 0x0, 0x4, 0x8 and 0xC.
- Drives the board LEDs in static, blink or PWM mode from those registers.
- Every register reads back exactly what was written, so the existing write/readback sequence passes unchanged.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte-address width; decoding uses bits [3:2].
- NUM_LEDS, 8, number of LED outputs, 1..32.

Ports:
- s00_axi_aclk  in  1  sole clock.
- s00_axi_aresetn  in  1  reset; asynchronous assert, active-low.
- s00_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  write address.
- s00_axi_awprot  in  3  ignored.
- s00_axi_awvalid / s00_axi_awready  in / out  1  write-address handshake.
- s00_axi_wdata  in  32  write data.
- s00_axi_wstrb  in  4  byte enables.
- s00_axi_wvalid / s00_axi_wready  in / out  1  write-data handshake.
- s00_axi_bresp  out  2  write response; always 2'b00 (OKAY).
- s00_axi_bvalid / s00_axi_bready  out / in  1  write-response handshake.
- s00_axi_araddr  in  C_S_AXI_ADDR_WIDTH  read address.
- s00_axi_arprot  in  3  ignored.
- s00_axi_arvalid / s00_axi_arready  in / out  1  read-address handshake.
- s00_axi_rdata  out  32  read data.
- s00_axi_rresp  out  2  read response; always 2'b00 (OKAY).
- s00_axi_rvalid / s00_axi_rready  out / in  1  read-data handshake.
- led  out  NUM_LEDS  LED drive; 1 = on.

Behaviour:
- Reset (aresetn low, takes effect immediately without a clock):
  - All ready and valid outputs, rdata, led, all registers and all counters clear to 0.
  - An outstanding transaction is dropped; nothing is replayed after reset.
- Register map:
  - REG0 CTRL: bit0 EN; bits[2:1] MODE (0 static, 1 blink, 2 PWM, 3 treated as static).
  - REG1 PATTERN: bits[NUM_LEDS-1:0] select the active LEDs.
  - REG2 PERIOD: blink half-period in clocks.
  - REG3 DUTY: bits[7:0] PWM duty.
  - All 32 bits of every register are stored and read back, including unused bits.
- Write channel:
  - awready and wready pulse high together for one cycle when awvalid && wvalid && !awready && !bvalid.
  - Registers update on that same edge, per byte, from wstrb.
  - bvalid rises on the next cycle and holds until bready. No new write is accepted while bvalid is high.
  - AW arriving without W, or W without AW: wait; neither ready asserts until both valids are high.
- Read channel:
  - arready pulses for one cycle when arvalid && !arready && !rvalid.
  - rdata is registered from araddr[3:2]; rvalid rises the following cycle.
  - rdata and rvalid hold until rready.
  - Simultaneous read and write to the same register: the read returns the pre-write value.
- LED output (registered, one clock after the state that produces it):
  - EN = 0: led = 0.
  - Static: led = PATTERN.
  - Blink:
    - A 32-bit counter runs 0..PERIOD-1; at wrap, phase toggles; led = PATTERN & {NUM_LEDS{phase}}.
    - PERIOD = 0 or 1: phase toggles every clock.
    - Any write to REG2 or REG0 clears the counter and sets phase = 1.
  - PWM:
    - An 8-bit counter free-runs 0..255 and wraps to 0.
    - led = PATTERN when counter < DUTY[7:0], otherwise 0.
    - DUTY = 0: LEDs always off. DUTY = 255: on 255 of every 256 clocks.
- Counters run only while EN = 1 and the matching mode is selected. Otherwise they are held at 0, with phase = 1.

Decomposition:
- Shared package axi_lite_led_pkg:
  - Register offsets REG_CTRL = 2'd0, REG_PATTERN = 2'd1, REG_PERIOD = 2'd2, REG_DUTY = 2'd3.
  - Mode constants MODE_STATIC / MODE_BLINK / MODE_PWM.
  - RESP_OKAY = 2'b00.
- One sub-module, led_pattern_gen:
  - Contains the blink and PWM counters and the output mux.
  - Inputs: ctrl, pattern, period, duty, restart pulse.
  - Output: led.
- The top level holds the AXI handshake logic and the register file.

Test Plan:
- Write/readback: write 0x0101FFFF, 0xABCD0001, 0xDEAD0011, 0xBEEF0011 to offsets 0, 4, 8, C -> each read returns the same value; bresp = rresp = 00.
- Byte strobes: REG1 = 0x11223344, then write 0xAABBCCDD with wstrb = 0101 -> readback 0x11BB33DD.
- Static mode: PATTERN = 0xA5, CTRL = 0x1 -> led = 0xA5 within 2 clocks. CTRL = 0x0 -> led = 0x00.
- Blink and PWM:
  - PATTERN = 0xFF, PERIOD = 4, CTRL = 0x3 -> led alternates 0xFF / 0x00 every 4 clocks.
  - PWM with DUTY = 64, CTRL = 0x5 -> led = 0xFF for exactly 64 of every 256 clocks.
- Handshake:
  - AW valid 3 cycles before W -> awready/wready pulse once, after W arrives.
  - bready held low 5 cycles -> bvalid stays high and a second write is stalled.
  - rready low -> rdata is stable.
- Reset mid-transaction: assert aresetn low while bvalid is high -> bvalid, led and all registers = 0 immediately; after release, reads return 0.
